input_vc_buffer: RTL
====================

# input_vc_buffer

Router input-port buffer: the receiving end of the flit link driven by an upstream router's output switch. Accepts `in_wr_en`/`flit_in`, steers each flit by its one-hot VC field into a per-VC FIFO, and presents per-VC head flits to the local switch allocator. Returns one credit pulse per flit read so the upstream OVC credit counters stay consistent.

## Interface
- `VC_NUM_PER_PORT`, 4: VCs per port.
- `PYLD_WIDTH`, 32: payload bits.
- `FLIT_TYPE_WIDTH`, 2: flit type bits.
- `VC_ID_WIDTH`, `VC_NUM_PER_PORT`: one-hot VC field.
- `FLIT_WIDTH`, `PYLD_WIDTH+FLIT_TYPE_WIDTH+VC_ID_WIDTH`.
- `BUF_DEPTH`, 4: flits per VC; a power of 2, ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `in_wr_en`  in  1  flit valid on `flit_in` this cycle.
- `flit_in`  in  FLIT_WIDTH  `{type, vc_onehot, payload}`, with type in the MSBs.
- `rd_vc`  in  VC_NUM_PER_PORT  one-hot pop request from the switch allocator; 0 means idle.
- `flit_out`  out  FLIT_WIDTH  head flit of the VC selected by `rd_vc`, combinational (FWFT).
- `vc_not_empty`  out  VC_NUM_PER_PORT  per-VC occupancy > 0.
- `vc_head_is_hdr`  out  VC_NUM_PER_PORT  head flit type is header (2'b10) or single (2'b11).
- `credit_out`  out  VC_NUM_PER_PORT  registered one-hot credit return pulse.
- `overflow_err`  out  1  sticky: a write hit a full VC.
- `underflow_err`  out  1  sticky: a read hit an empty VC.

## Operation
- Flit type encoding: 2'b10 header, 2'b00 body, 2'b01 tail, 2'b11 single-flit.
- Storage is one array of `VC_NUM_PER_PORT*BUF_DEPTH` entries. VC v owns the region `v*BUF_DEPTH`. Each VC has a log2(BUF_DEPTH)-bit write pointer, a log2(BUF_DEPTH)-bit read pointer, and a log2(BUF_DEPTH)+1-bit count. Pointers wrap modulo `BUF_DEPTH`.
- Write: when `in_wr_en` is set, decode the one-hot VC field. If count < `BUF_DEPTH`, store the full flit (VC field unchanged) at wr_ptr, then wr_ptr+1 and count+1. If the VC is full, drop the flit and set `overflow_err`.
- `in_wr_en` with a VC field that is zero or not one-hot is dropped and sets `overflow_err`.
- Read: when `rd_vc` is one-hot and that VC is not empty, `flit_out` shows the entry at its rd_ptr. At the edge, rd_ptr+1 and count−1, and `credit_out[v]` is 1 in the next cycle. A read of an empty VC changes no state, sends no credit and sets `underflow_err`. A `rd_vc` that is not one-hot is treated as an underflow error with no state change.
- `flit_out` is all zeros when `rd_vc`==0 or the selected VC is empty.
- Same VC read and written in one cycle: count is unchanged and both pointers advance. The full check uses the count before the edge, so a write to a full VC is dropped even if that VC is read in the same cycle. Credit flow control makes this case illegal.
- A write to VC a and a read of VC b≠a in the same cycle are independent.
- Error flags clear only on reset.
- Reset clears all pointers, counts, `credit_out`, and both error flags. Storage contents are not reset. All outputs are 0 after reset: `flit_out` is 0 because every VC is empty. A reset mid-packet discards all buffered flits with no credits returned.

## Timing
- Write-to-visible: a flit written at edge N sets `vc_not_empty` and is readable in cycle N+1. There is no same-cycle bypass.
- Read: zero-latency data (FWFT). The pop occurs at the edge ending the read cycle.
- Credit: a pop in cycle N gives a `credit_out` pulse for exactly cycle N+1. Back-to-back pops give back-to-back pulses.
- Sustained throughput is 1 write and 1 read per cycle.

## Structure
- Shared package `noc_pkg`: flit type constants (HDR, BODY, TAIL, SINGLE) and flit field slice positions. The same definitions are reused by the output switch and the OVC status logic.
- One natural sub-module, `vc_fifo_ctrl`: pointers and count for one VC, instantiated `VC_NUM_PER_PORT` times. The storage array and output mux stay in the top.

## Test plan
- Reset, then write a header flit to VC1 (`vc_onehot`=4'b0010, payload 0xA5A5A5A5) → `vc_not_empty`=4'b0010 and `vc_head_is_hdr[1]`=1 next cycle. With `rd_vc`=4'b0010, `flit_out` equals the written flit and `credit_out`=4'b0010 for one cycle after the pop.
- Fill VC0 with 4 flits (payloads 0..3), then write a 5th → `overflow_err`=1 and count stays 4. Four reads return payloads 0,1,2,3 in order and give four credit pulses.
- Continuous streaming: write and read VC2 in the same cycle for 10 cycles after priming one flit → `vc_not_empty[2]` stays 1, data is in order, and pointers wrap cleanly past entry 3.
- Interleaved writes to VC0/VC3 with reads of VC3 only → VC0 data is untouched and credits go only to bit 3.
- Read VC1 while it is empty → `underflow_err`=1, `credit_out`=0, `flit_out`=0.
- Assert reset with 3 flits held in VC2 → all outputs 0 immediately (async). After release, `vc_not_empty`=0 and the error flags are cleared.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: flit type encoding and field helpers shared by router input, switch and OVC logic
package noc_pkg;
  localparam int TYPE_W = 2;
  typedef enum logic [TYPE_W-1:0] {BODY = 2'b00, TAIL = 2'b01, HDR = 2'b10, SINGLE = 2'b11} flit_type_e;
  // Flit layout is {type, vc_onehot, payload}; fields are located from the payload/VC widths
  function automatic int vc_lsb(input int pyld_w);
    return pyld_w;
  endfunction
  function automatic int type_lsb(input int pyld_w, input int vc_w);
    return pyld_w + vc_w;
  endfunction
  function automatic logic is_hdr(input logic [TYPE_W-1:0] t);
    return t == HDR || t == SINGLE;
  endfunction
endpackage

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: pointer and occupancy tracking for one VC region of the shared flit store
module vc_fifo_ctrl #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  output logic          wr_fire,
  output logic          rd_fire,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr
);
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_fire = wr && !full;
  assign rd_fire = rd && !empty;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (wr_fire != rd_fire) count <= wr_fire ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: rtl/input_vc_buffer.sv
// input_vc_buffer: router input port; steers flits into per-VC FIFOs, FWFT head per VC, credit return
module input_vc_buffer
  import noc_pkg::*;
#(
  parameter int VC_NUM_PER_PORT = 4,
  parameter int PYLD_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int VC_ID_WIDTH = VC_NUM_PER_PORT,
  parameter int FLIT_WIDTH = PYLD_WIDTH + FLIT_TYPE_WIDTH + VC_ID_WIDTH,
  parameter int BUF_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_wr_en,
  input  logic [FLIT_WIDTH-1:0]      flit_in,
  input  logic [VC_NUM_PER_PORT-1:0] rd_vc,
  output logic [FLIT_WIDTH-1:0]      flit_out,
  output logic [VC_NUM_PER_PORT-1:0] vc_not_empty,
  output logic [VC_NUM_PER_PORT-1:0] vc_head_is_hdr,
  output logic [VC_NUM_PER_PORT-1:0] credit_out,
  output logic                       overflow_err,
  output logic                       underflow_err
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int N = VC_NUM_PER_PORT * BUF_DEPTH;
  localparam int IW = $clog2(N);
  logic [FLIT_WIDTH-1:0] mem [N];
  logic [VC_ID_WIDTH-1:0] vc_field;
  logic wr_oh, rd_oh;
  logic [VC_NUM_PER_PORT-1:0] wr_req, rd_req, wr_fire, rd_fire, full, empty;
  logic [VC_NUM_PER_PORT-1:0][AW-1:0] wr_ptr, rd_ptr;
  logic [VC_NUM_PER_PORT-1:0][FLIT_WIDTH-1:0] head;
  logic [IW-1:0] wr_idx;
  assign vc_field = flit_in[vc_lsb(PYLD_WIDTH) +: VC_ID_WIDTH];
  assign wr_oh = $onehot(vc_field);
  assign rd_oh = $onehot(rd_vc);
  assign wr_req = (in_wr_en && wr_oh) ? vc_field : '0;
  assign rd_req = rd_oh ? rd_vc : '0;
  assign vc_not_empty = ~empty;
  for (genvar v = 0; v < VC_NUM_PER_PORT; v++) begin : g_vc
    vc_fifo_ctrl #(.DEPTH(BUF_DEPTH)) u_ctrl (
      .clk(clk), .reset(reset), .wr(wr_req[v]), .rd(rd_req[v]),
      .wr_fire(wr_fire[v]), .rd_fire(rd_fire[v]), .full(full[v]), .empty(empty[v]),
      .wr_ptr(wr_ptr[v]), .rd_ptr(rd_ptr[v])
    );
    assign head[v] = mem[IW'(v * BUF_DEPTH) + IW'(rd_ptr[v])];
    assign vc_head_is_hdr[v] = !empty[v] && is_hdr(head[v][type_lsb(PYLD_WIDTH, VC_ID_WIDTH) +: FLIT_TYPE_WIDTH]);
  end
  always_comb begin
    wr_idx = '0;
    for (int v = 0; v < VC_NUM_PER_PORT; v++)
      if (wr_fire[v]) wr_idx = IW'(v * BUF_DEPTH) + IW'(wr_ptr[v]);
  end
  // rd_fire is only set for a one-hot request to a non-empty VC, so it doubles as the output select
  always_comb begin
    flit_out = '0;
    for (int v = 0; v < VC_NUM_PER_PORT; v++)
      if (rd_fire[v]) flit_out = head[v];
  end
  always_ff @(posedge clk) begin
    if (|wr_fire) mem[wr_idx] <= flit_in;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_out <= '0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      credit_out <= rd_fire;
      if (in_wr_en && (!wr_oh || |(wr_req & full))) overflow_err <= 1'b1;
      if (|rd_vc && (!rd_oh || |(rd_req & empty))) underflow_err <= 1'b1;
    end
  end
endmodule
